// File: rtl/aria_io_ctrl_if.sv
// Host-side bus of aria_io_ctrl: key-load, block-input and result handshakes.
// The host drives through the master modport and the controller uses the slave modport.
interface aria_io_ctrl_if;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [1:0]   cfg_mode;
    logic [255:0] cfg_key;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] din;
    logic         din_dec;
    logic         dout_valid;
    logic         dout_ready;
    logic [127:0] dout;

    modport master (
        output cfg_valid, cfg_mode, cfg_key, din_valid, din, din_dec, dout_ready,
        input  cfg_ready, din_ready, dout_valid, dout
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_key, din_valid, din, din_dec, dout_ready,
        output cfg_ready, din_ready, dout_valid, dout
    );
endinterface

// File: rtl/aria_io_ctrl.sv
// ARIA I/O controller: sequences key loading, block processing and result hand-off.
// Optional ARIA_IO_TIMEOUT_EN adds a watchdog on the key-schedule and block wait states.
module aria_io_ctrl (
    input  logic           clk,
    input  logic           rst,
    aria_io_ctrl_if.slave  host,
    output logic [1:0]     aria_mode,
    output logic [255:0]   key,
    output logic           run,
    input  logic           ks_done,
    output logic           blk_start,
    output logic [127:0]   blk_din,
    output logic           blk_dec,
    input  logic           blk_done,
    input  logic [127:0]   blk_dout,
    output logic           key_valid,
    output logic           busy,
    output logic           err
);

    typedef enum logic [2:0] {
        StNoKey, StKsRun, StKsWait, StReady, StBlkRun, StBlkWait, StOutHold
    } state_e;

    state_e state_q;

`ifdef ARIA_IO_TIMEOUT_EN
    logic [7:0] wd_q;
`endif

    // Key is left-aligned; bits beyond the selected key length are dropped.
    function automatic logic [255:0] mask_key(input logic [1:0] mode, input logic [255:0] k);
        logic [255:0] m;
        case (mode)
            2'b00:   m = {{128{1'b1}}, {128{1'b0}}};
            2'b01:   m = {{192{1'b1}}, {64{1'b0}}};
            default: m = {256{1'b1}};
        endcase
        return k & m;
    endfunction

    logic idle_state;
    assign idle_state     = (state_q == StNoKey) || (state_q == StReady);
    assign host.cfg_ready = idle_state;
    assign host.din_ready = (state_q == StReady) && !host.cfg_valid;
    assign busy           = !idle_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StNoKey;
            aria_mode       <= 2'b00;
            key             <= '0;
            run             <= 1'b0;
            blk_start       <= 1'b0;
            blk_din         <= '0;
            blk_dec         <= 1'b0;
            key_valid       <= 1'b0;
            err             <= 1'b0;
            host.dout       <= '0;
            host.dout_valid <= 1'b0;
`ifdef ARIA_IO_TIMEOUT_EN
            wd_q            <= '0;
`endif
        end else begin
            run       <= 1'b0;
            blk_start <= 1'b0;
            unique case (state_q)
                StNoKey, StReady: begin
                    if (host.cfg_valid) begin
                        if (host.cfg_mode == 2'b11) begin
                            // Illegal mode is consumed but leaves the key untouched.
                            err <= 1'b1;
                        end else begin
                            aria_mode <= host.cfg_mode;
                            key       <= mask_key(host.cfg_mode, host.cfg_key);
                            key_valid <= 1'b0;
                            err       <= 1'b0;
                            run       <= 1'b1;
                            state_q   <= StKsRun;
                        end
                    end else if (state_q == StReady && host.din_valid) begin
                        blk_din   <= host.din;
                        blk_dec   <= host.din_dec;
                        blk_start <= 1'b1;
                        state_q   <= StBlkRun;
                    end
                end
                StKsRun: begin
                    state_q <= StKsWait;
`ifdef ARIA_IO_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                StKsWait: begin
                    if (ks_done) begin
                        key_valid <= 1'b1;
                        state_q   <= StReady;
                    end
`ifdef ARIA_IO_TIMEOUT_EN
                    else if (wd_q == 8'd254) begin
                        err       <= 1'b1;
                        key_valid <= 1'b0;
                        state_q   <= StNoKey;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
`endif
                end
                StBlkRun: begin
                    state_q <= StBlkWait;
`ifdef ARIA_IO_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                StBlkWait: begin
                    if (blk_done) begin
                        host.dout       <= blk_dout;
                        host.dout_valid <= 1'b1;
                        state_q         <= StOutHold;
                    end
`ifdef ARIA_IO_TIMEOUT_EN
                    else if (wd_q == 8'd254) begin
                        err       <= 1'b1;
                        key_valid <= 1'b0;
                        state_q   <= StNoKey;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
`endif
                end
                StOutHold: begin
                    if (host.dout_ready) begin
                        host.dout_valid <= 1'b0;
                        state_q         <= StReady;
                    end
                end
                default: state_q <= StNoKey;
            endcase
        end
    end

endmodule

// File: tb/tb_aria_io_ctrl.sv
// Self-checking bench for aria_io_ctrl; results go through a scoreboard queue.
// Watchdog expectations follow ARIA_IO_TIMEOUT_EN when it is defined.
module tb_aria_io_ctrl;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     aria_mode;
    logic [255:0]   key;
    logic           run;
    logic           ks_done = 1'b0;
    logic           blk_start;
    logic [127:0]   blk_din;
    logic           blk_dec;
    logic           blk_done = 1'b0;
    logic [127:0]   blk_dout = '0;
    logic           key_valid;
    logic           busy;
    logic           err;

    aria_io_ctrl_if bus ();

    aria_io_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus),
        .aria_mode (aria_mode),
        .key       (key),
        .run       (run),
        .ks_done   (ks_done),
        .blk_start (blk_start),
        .blk_din   (blk_din),
        .blk_dec   (blk_dec),
        .blk_done  (blk_done),
        .blk_dout  (blk_dout),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    logic [127:0] exp_q[$];

    localparam logic [255:0] K1 =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [255:0] K2 =
        256'hF0E1D2C3B4A5968778695A4B3C2D1E0F0123456789ABCDEFFEDCBA9876543210;
    localparam logic [255:0] K3 =
        256'h1111222233334444555566667777888899990000AAAABBBBCCCCDDDDEEEEFFFF;

    function automatic logic [255:0] exp_key(input logic [1:0] mode, input logic [255:0] k);
        logic [255:0] r;
        r = k;
        if (mode == 2'b00) r[127:0] = '0;
        if (mode == 2'b01) r[63:0] = '0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_vec++; if (bus.cfg_ready !== 1'b1) begin n_miss++; $display("FAIL rst_cfg_ready: got %0b want 1", bus.cfg_ready); end
        n_vec++; if (bus.din_ready !== 1'b0) begin n_miss++; $display("FAIL rst_din_ready: got %0b want 0", bus.din_ready); end
        n_vec++; if ({run, blk_start, key_valid, bus.dout_valid, err, busy} !== 6'b0) begin n_miss++; $display("FAIL rst_flags: got %b want 000000", {run, blk_start, key_valid, bus.dout_valid, err, busy}); end
        n_vec++; if (aria_mode !== 2'b00 || key !== '0) begin n_miss++; $display("FAIL rst_key: got mode %0d key %h want 0/0", aria_mode, key); end
        n_vec++; if (bus.dout !== '0 || blk_din !== '0 || blk_dec !== 1'b0) begin n_miss++; $display("FAIL rst_data: got dout %h blk_din %h dec %0b want 0", bus.dout, blk_din, blk_dec); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_key_load();
        int runs = 0;
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b00; bus.cfg_key = K1;
        tick();
        bus.cfg_valid = 1'b0;
        n_vec++; if (run !== 1'b1) begin n_miss++; $display("FAIL kl_run: got %0b want 1", run); end
        n_vec++; if (key !== exp_key(2'b00, K1) || aria_mode !== 2'b00) begin n_miss++; $display("FAIL kl_key: got %0d/%h want 0/%h", aria_mode, key, exp_key(2'b00, K1)); end
        n_vec++; if (busy !== 1'b1 || bus.cfg_ready !== 1'b0 || key_valid !== 1'b0) begin n_miss++; $display("FAIL kl_busy: got busy %0b cfg_ready %0b kv %0b want 1 0 0", busy, bus.cfg_ready, key_valid); end
        for (int i = 0; i < 19; i++) begin
            tick();
            if (run) runs++;
        end
        n_vec++; if (runs != 0) begin n_miss++; $display("FAIL kl_run_width: got %0d extra run cycles want 0", runs); end
        ks_done = 1'b1;
        tick();
        ks_done = 1'b0;
        n_vec++; if (key_valid !== 1'b1 || busy !== 1'b0 || bus.din_ready !== 1'b1) begin n_miss++; $display("FAIL kl_ready: got kv %0b busy %0b din_ready %0b want 1 0 1", key_valid, busy, bus.din_ready); end
    endtask

    task automatic test_ignore();
        ks_done = 1'b1; blk_done = 1'b1; blk_dout = 128'hDEAD;
        tick();
        ks_done = 1'b0; blk_done = 1'b0;
        n_vec++; if (bus.dout_valid !== 1'b0 || busy !== 1'b0 || run !== 1'b0 || key_valid !== 1'b1) begin n_miss++; $display("FAIL ign_ready: got dv %0b busy %0b run %0b kv %0b want 0 0 0 1", bus.dout_valid, busy, run, key_valid); end
    endtask

    task automatic test_encrypt_backpressure();
        logic [127:0] d;
        d = 128'h00112233445566778899AABBCCDDEEFF;
        bus.din = d; bus.din_dec = 1'b0; bus.din_valid = 1'b1; bus.dout_ready = 1'b0;
        tick();
        bus.din_valid = 1'b0;
        n_vec++; if (blk_start !== 1'b1 || blk_din !== d || blk_dec !== 1'b0) begin n_miss++; $display("FAIL enc_start: got %0b %h %0b want 1 %h 0", blk_start, blk_din, blk_dec, d); end
        tick();
        n_vec++; if (blk_start !== 1'b0 || busy !== 1'b1) begin n_miss++; $display("FAIL enc_start_pulse: got start %0b busy %0b want 0 1", blk_start, busy); end
        tick(); tick();
        blk_done = 1'b1; blk_dout = d ^ {4{32'hA5A5_5A5A}};
        exp_q.push_back(d ^ {4{32'hA5A5_5A5A}});
        tick();
        blk_done = 1'b0; blk_dout = '0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout !== exp_q[0] || bus.din_ready !== 1'b0) begin n_miss++; $display("FAIL enc_hold%0d: got dv %0b dout %h dr %0b want 1 %h 0", i, bus.dout_valid, bus.dout, bus.din_ready, exp_q[0]); end
            if (i < 4) tick();
        end
        bus.dout_ready = 1'b1;
        d = exp_q.pop_front();
        n_vec++; if (bus.dout !== d) begin n_miss++; $display("FAIL enc_dout: got %h want %h", bus.dout, d); end
        tick();
        bus.dout_ready = 1'b0;
        n_vec++; if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || busy !== 1'b0) begin n_miss++; $display("FAIL enc_ready: got dv %0b dr %0b busy %0b want 0 1 0", bus.dout_valid, bus.din_ready, busy); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        logic [127:0] e;
        bus.dout_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            bus.din = d; bus.din_dec = 1'b1; bus.din_valid = 1'b1;
            tick();
            bus.din_valid = 1'b0;
            n_vec++; if (blk_start !== 1'b1 || blk_din !== d || blk_dec !== 1'b1) begin n_miss++; $display("FAIL b2b_start%0d: got %0b %h %0b want 1 %h 1", n, blk_start, blk_din, blk_dec, d); end
            tick();
            blk_done = 1'b1; blk_dout = ~d;
            exp_q.push_back(~d);
            tick();
            blk_done = 1'b0;
            if (exp_q.size() == 0) e = '0; else e = exp_q.pop_front();
            n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout !== e) begin n_miss++; $display("FAIL b2b_dout%0d: got %0b %h want 1 %h", n, bus.dout_valid, bus.dout, e); end
            tick();
            n_vec++; if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready%0d: got dv %0b dr %0b want 0 1", n, bus.dout_valid, bus.din_ready); end
        end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_cfg_priority();
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b01; bus.cfg_key = K2;
        bus.din_valid = 1'b1; bus.din = 128'h1;
        #1;
        n_vec++; if (bus.din_ready !== 1'b0 || bus.cfg_ready !== 1'b1) begin n_miss++; $display("FAIL pri_ready: got din_ready %0b cfg_ready %0b want 0 1", bus.din_ready, bus.cfg_ready); end
        tick();
        bus.cfg_valid = 1'b0; bus.din_valid = 1'b0;
        n_vec++; if (run !== 1'b1 || blk_start !== 1'b0 || key_valid !== 1'b0) begin n_miss++; $display("FAIL pri_accept: got run %0b start %0b kv %0b want 1 0 0", run, blk_start, key_valid); end
        n_vec++; if (aria_mode !== 2'b01 || key !== exp_key(2'b01, K2)) begin n_miss++; $display("FAIL pri_key: got %0d/%h want 1/%h", aria_mode, key, exp_key(2'b01, K2)); end
        tick(); tick();
        ks_done = 1'b1;
        tick();
        ks_done = 1'b0;
        n_vec++; if (key_valid !== 1'b1) begin n_miss++; $display("FAIL pri_kv: got %0b want 1", key_valid); end
    endtask

    task automatic test_illegal_mode();
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b11; bus.cfg_key = ~K2;
        tick();
        bus.cfg_valid = 1'b0;
        n_vec++; if (err !== 1'b1 || key_valid !== 1'b1 || run !== 1'b0) begin n_miss++; $display("FAIL ill_flags: got err %0b kv %0b run %0b want 1 1 0", err, key_valid, run); end
        n_vec++; if (aria_mode !== 2'b01 || key !== exp_key(2'b01, K2) || bus.cfg_ready !== 1'b1) begin n_miss++; $display("FAIL ill_key: got %0d/%h cfg_ready %0b want 1/%h 1", aria_mode, key, bus.cfg_ready, exp_key(2'b01, K2)); end
        tick();
        n_vec++; if (err !== 1'b1 || run !== 1'b0) begin n_miss++; $display("FAIL ill_sticky: got err %0b run %0b want 1 0", err, run); end
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b10; bus.cfg_key = K3;
        tick();
        bus.cfg_valid = 1'b0;
        n_vec++; if (err !== 1'b0 || run !== 1'b1 || aria_mode !== 2'b10 || key !== K3) begin n_miss++; $display("FAIL ill_clear: got err %0b run %0b mode %0d key %h want 0 1 2 %h", err, run, aria_mode, key, K3); end
        tick();
        ks_done = 1'b1;
        tick();
        ks_done = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        bus.din = 128'hCAFE; bus.din_dec = 1'b0; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        n_vec++; if ({run, blk_start, key_valid, bus.dout_valid, err, busy} !== 6'b0 || bus.cfg_ready !== 1'b1 || bus.din_ready !== 1'b0) begin n_miss++; $display("FAIL mid_flags: got %b cr %0b dr %0b want 000000 1 0", {run, blk_start, key_valid, bus.dout_valid, err, busy}, bus.cfg_ready, bus.din_ready); end
        n_vec++; if (aria_mode !== 2'b00 || key !== '0 || blk_din !== '0 || bus.dout !== '0) begin n_miss++; $display("FAIL mid_data: got %0d %h %h %h want all 0", aria_mode, key, blk_din, bus.dout); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        blk_done = 1'b1; blk_dout = 128'hBAD;
        tick();
        blk_done = 1'b0;
        n_vec++; if (bus.dout_valid !== 1'b0 || bus.dout !== '0 || busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin n_miss++; $display("FAIL mid_ignore: got dv %0b dout %h busy %0b cr %0b want 0 0 0 1", bus.dout_valid, bus.dout, busy, bus.cfg_ready); end
    endtask

    task automatic test_watchdog();
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b00; bus.cfg_key = K1;
        tick();
        bus.cfg_valid = 1'b0;
        tick();
`ifdef ARIA_IO_TIMEOUT_EN
        for (int i = 0; i < 254; i++) tick();
        n_vec++; if (busy !== 1'b1 || err !== 1'b0) begin n_miss++; $display("FAIL wd_early: got busy %0b err %0b want 1 0", busy, err); end
        tick();
        n_vec++; if (err !== 1'b1 || busy !== 1'b0 || bus.cfg_ready !== 1'b1 || key_valid !== 1'b0) begin n_miss++; $display("FAIL wd_fire: got err %0b busy %0b cr %0b kv %0b want 1 0 1 0", err, busy, bus.cfg_ready, key_valid); end
`else
        for (int i = 0; i < 1000; i++) tick();
        n_vec++; if (busy !== 1'b1 || bus.cfg_ready !== 1'b0 || err !== 1'b0) begin n_miss++; $display("FAIL wd_none: got busy %0b cr %0b err %0b want 1 0 0", busy, bus.cfg_ready, err); end
`endif
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_mode = 2'b00; bus.cfg_key = '0;
        bus.din_valid = 1'b0; bus.din = '0; bus.din_dec = 1'b0; bus.dout_ready = 1'b0;
        test_reset();
        test_key_load();
        test_ignore();
        test_encrypt_backpressure();
        test_back_to_back();
        test_cfg_priority();
        test_illegal_mode();
        test_reset_mid_op();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no completion want completion within time limit");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/aria_io_ctrl.md
ARIA_IO_CTRL -- requirements
Module: aria_io_ctrl

Interface
REQ-001 clk  in  1  Sole clock; all state updates on rising edge.
REQ-002 rst  in  1  Reset, asynchronous and active-high.
REQ-003 cfg_valid / cfg_ready  in / out  1 / 1  Key-load handshake; a transfer occurs when both are high on a clk edge.
REQ-004 cfg_mode / cfg_key  in  2 / 256  Mode: 00=128, 01=192, 10=256, 11=illegal. Key is left-aligned; unused LSBs are ignored.
REQ-005 din_valid / din_ready / din / din_dec  in / out / in / in  1 / 1 / 128 / 1  Block-input handshake; din_dec=1 selects decrypt.
REQ-006 dout_valid / dout_ready / dout  out / in / out  1 / 1 / 128  Result handshake.
REQ-007 aria_mode / key  out  2 / 256  Registered mode and key driven to the control unit and key schedule.
REQ-008 run  out  1  One-cycle pulse that starts key expansion.
REQ-009 ks_done  in  1  One-cycle pulse; key schedule complete (control unit DONE state).
REQ-010 blk_start / blk_din / blk_dec  out  1 / 128 / 1  One-cycle start pulse plus registered block data and direction.
REQ-011 blk_done / blk_dout  in  1 / 128  One-cycle pulse with the round datapath result.
REQ-012 key_valid / busy / err  out  1 / 1 / 1  Key schedule usable; FSM not in NOKEY/READY; sticky error flag.

Function
REQ-013 FSM states: NOKEY, KS_RUN, KS_WAIT, READY, BLK_RUN, BLK_WAIT, OUT_HOLD. All state is held in registers.
REQ-014 cfg_ready SHALL be high only in NOKEY and READY.
- A legal cfg transfer captures cfg_mode and cfg_key, clears key_valid, and enters KS_RUN.
REQ-015 KS_RUN SHALL assert run for exactly one cycle, then go to KS_WAIT.
REQ-016 KS_WAIT: ks_done SHALL set key_valid and go to READY.
- ks_done in any other state is ignored.
REQ-017 din_ready SHALL be high only in READY with cfg_valid low.
- cfg has priority over din when both are valid.
REQ-018 A din transfer captures din and din_dec into blk_din and blk_dec, then enters BLK_RUN.
REQ-019 BLK_RUN SHALL pulse blk_start for one cycle, then go to BLK_WAIT.
REQ-020 BLK_WAIT: blk_done SHALL capture blk_dout into dout and go to OUT_HOLD.
REQ-021 OUT_HOLD: dout_valid SHALL be high and dout stable until dout_ready.
- When dout_ready is seen, go to READY.
- The next din is accepted no earlier than the following cycle.
REQ-022 Minimum cfg-to-run latency SHALL be 1 cycle (run is high in the cycle after the transfer).
- Minimum din-to-blk_start latency SHALL be 1 cycle.
REQ-023 A cfg transfer with cfg_mode=11 SHALL be consumed and set err.
- State, key, aria_mode and key_valid are unchanged.
REQ-024 cfg_valid, din_valid, ks_done and blk_done arriving in non-accepting states SHALL have no effect.
REQ-025 err SHALL clear only on reset or on a subsequent legal cfg transfer.
REQ-026 busy SHALL be high in KS_RUN, KS_WAIT, BLK_RUN, BLK_WAIT and OUT_HOLD.

Reset
REQ-027 rst high SHALL immediately force NOKEY, regardless of the operation in progress, with these outputs:
- run, blk_start, key_valid, dout_valid, err, busy = 0.
- cfg_ready = 1; din_ready = 0.
- aria_mode = 00; key, dout, blk_din, blk_dec = 0.
REQ-028 The first edge after rst deasserts SHALL be able to accept cfg.

Configuration
REQ-029 Macro ARIA_IO_TIMEOUT_EN, when defined, adds an 8-bit watchdog counter:
- The counter clears on entry to KS_WAIT or BLK_WAIT.
- It increments each cycle spent in those states.
- On reaching 255 it sets err, clears key_valid and forces NOKEY.
REQ-030 Without ARIA_IO_TIMEOUT_EN there SHALL be no counter, and KS_WAIT/BLK_WAIT wait indefinitely.

Verification
REQ-031 Legal 128-bit key load:
- Stimulus: reset; cfg_mode=00, cfg_key=000102..1F; ks_done 20 cycles after run.
- Response: run high exactly 1 cycle, 1 cycle after the transfer; key_valid=1 the cycle after ks_done; aria_mode=00.
REQ-032 Encrypt block with output backpressure:
- Stimulus: din=00112233445566778899AABBCCDDEEFF, din_dec=0; blk_done with a fixed pattern; dout_ready held low 5 cycles.
- Response: dout_valid held and dout stable for 5 cycles; READY reached 1 cycle after dout_ready.
REQ-033 Simultaneous cfg_valid and din_valid in READY:
- Response: cfg accepted, din_ready=0, key_valid drops.
REQ-034 Illegal mode:
- Stimulus: cfg_mode=11 with key_valid=1.
- Response: err=1; key_valid remains 1; no run pulse.
REQ-035 Reset mid-operation:
- Stimulus: assert rst in BLK_WAIT.
- Response: all outputs at reset values in the same cycle; a later blk_done is ignored.
REQ-036 Watchdog (ARIA_IO_TIMEOUT_EN defined):
- Stimulus: withhold ks_done.
- Response: err=1 and state NOKEY 255 cycles after entering KS_WAIT.
- Without the macro: still in KS_WAIT after 1000 cycles.
